circuito_gerador_vetores_comparador: RTL and testbench
======================================================

Name: circuito_gerador_vetores_comparador

Overview:
- Sequential stimulus generator and checker for the 6-input equality comparator (inputs A..F, output FI).
- Sweeps all 64 input combinations and drives them onto A..F. Samples FI after a settle window and checks it against a golden equality model.
- Accumulates match and error counts, then reports pass/fail. It sits on the opposite side of the comparator, driving its inputs and consuming its output.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before FI is sampled. Legal range is 1..15; values below 1 are illegal.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  run request; sampled only in IDLE or DONE
- FI  input  1  comparator output under check
- A  output  1  stimulus bit 5 (MSB of vector)
- B  output  1  stimulus bit 4
- C  output  1  stimulus bit 3
- D  output  1  stimulus bit 2
- E  output  1  stimulus bit 1
- F  output  1  stimulus bit 0 (LSB)
- busy  output  1  high in DRIVE and SAMPLE
- done  output  1  high in DONE until next accepted start or reset
- pass  output  1  valid while done=1; 1 when error_count==0 and match_count==8
- match_count  output  7  number of vectors where FI sampled 1 (range 0..64)
- error_count  output  7  number of vectors where FI differed from expected (range 0..64)

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, A..F=0, busy=0, done=0, pass=0, match_count=0, error_count=0, internal vector counter vec[5:0]=0, settle counter=0.
- Mapping: {A,B,C,D,E,F} = vec[5:0], all registered outputs. Golden model: expected = (A==D)&(B==F)&(C==E), evaluated on the currently driven vector.
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
- IDLE/DONE with start=1:
  - Next state is DRIVE.
  - vec=0 (A..F=0), settle=SETTLE_CYCLES.
  - Counters are cleared, done=0, pass=0.
- IDLE/DONE with start=0: remain in the current state and hold all outputs.
- DRIVE: settle decrements each cycle. DRIVE lasts exactly SETTLE_CYCLES cycles, then the FSM moves to SAMPLE.
- SAMPLE (1 cycle), evaluated on FI in this cycle:
  - match_count += FI.
  - error_count += (FI != expected).
  - If vec==63, next state is DONE and vec holds.
  - Otherwise vec+1, settle=SETTLE_CYCLES, next state is DRIVE.
- Timing: vector k is on A..F for cycles k*(S+1) through k*(S+1)+S after the start-accept edge. done rises at edge 64*(S+1), where S=SETTLE_CYCLES.
- Counters are 7 bits wide. The maximum value is 64, so overflow is impossible.
- start while busy is ignored, and the run continues unaffected.
- Reset asserted mid-run:
  - The next edge returns to IDLE with all reset values.
  - The partial counts are discarded.
- Reset has priority over start in the same cycle.
- In DONE, A..F hold vector 63 (all ones). pass is combinationally derived from the registered counters, gated by done.

Optional Feature:
- Macro: CIRCUITO_GERADOR_CAPTURA_ERRO_EN.
- When defined, two extra outputs are added:
  - first_err_valid (1 bit, reset 0).
  - first_err_vec (6 bits, reset 0).
- On the first SAMPLE cycle of a run with FI!=expected, first_err_vec latches vec and first_err_valid is set.
- Both outputs hold for the rest of the run and clear on start-accept or reset.
- When not defined, these ports and registers are absent and all other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=1, FI driven by a correct model (A==D & B==F & C==E); reset, pulse start -> done rises 128 cycles after the accept edge, match_count=8, error_count=0, pass=1.
- FI stuck at 0 -> match_count=0, error_count=8, pass=0. With the macro defined, first_err_valid=1 and first_err_vec=6'b000000.
- FI stuck at 1 -> match_count=64, error_count=56, pass=0. With the macro defined, first_err_vec=6'b000001.
- FI from a miswired model (A==D & B==E & C==F) -> match_count=8, error_count=8, pass=0.
- Start held high for the whole run, plus a second start pulse at vector 10 -> single run, done at cycle 128, counts as in test 1. With start still high in DONE, a new run begins the next cycle (done=0, vec=0).
- Reset asserted while vec=20 -> next edge: busy=0, done=0, A..F=0, counters=0. A fresh start then completes normally with pass=1.

Source files
------------

// File: rtl/circuito_gerador_vetores_comparador.sv
// circuito_gerador_vetores_comparador
// Stimulus generator and checker for a 6-input equality comparator.
// Sweeps all 64 vectors onto A..F, holds each for SETTLE_CYCLES cycles,
// samples FI for one cycle and compares it against the golden
// equality (A==D)&(B==F)&(C==E). Match and error counts are accumulated.
// pass is reported at the end of the run.
// SETTLE_CYCLES legal range: 1..15.
// Optional feature macro: CIRCUITO_GERADOR_CAPTURA_ERRO_EN
//   When defined, the module adds first_err_valid and first_err_vec.
//   These capture the first vector of a run whose FI sample was wrong.
module circuito_gerador_vetores_comparador #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       FI,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] match_count,
    output logic [6:0] error_count
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
   ,output logic       first_err_valid,
    output logic [5:0] first_err_vec
`endif
);

    // state     | meaning
    // ST_IDLE   | waiting for start after reset
    // ST_DRIVE  | vector on A..F, settle window counting down
    // ST_SAMPLE | one cycle: FI checked, counters updated
    // ST_DONE   | sweep finished, results held until next start
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state;
    logic [5:0] r_vec;
    logic [3:0] r_settle;
    logic [6:0] r_match;
    logic [6:0] r_err;
    logic       r_busy;
    logic       r_done;
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
    logic       r_first_err_valid;
    logic [5:0] r_first_err_vec;
`endif

    logic w_expected;
    logic w_mismatch;

    // Golden model evaluated on the vector currently driven onto A..F.
    // Vector bits map as A=vec[5], B=vec[4], C=vec[3], D=vec[2], E=vec[1] and F=vec[0].
    assign w_expected = (r_vec[5] == r_vec[2]) & (r_vec[4] == r_vec[0]) & (r_vec[3] == r_vec[1]);
    assign w_mismatch = FI ^ w_expected;

    // Sequencer: sweep vectors, hold each for the settle window, then sample and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_vec    <= 6'd0;
            r_settle <= 4'd0;
            r_match  <= 7'd0;
            r_err    <= 7'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 6'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_DRIVE;
                        r_vec    <= 6'd0;
                        r_settle <= LP_SETTLE;
                        r_match  <= 7'd0;
                        r_err    <= 7'd0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
                        r_first_err_valid <= 1'b0;
                        r_first_err_vec   <= 6'd0;
`endif
                    end
                end
                ST_DRIVE: begin
                    r_settle <= r_settle - 4'd1;
                    // The window ends after the cycle in which the counter shows 1.
                    // A count of 0 is treated the same way, so a bad parameter cannot hang the sweep.
                    if (r_settle <= 4'd1) begin
                        r_state  <= ST_SAMPLE;
                        r_settle <= 4'd0;
                    end
                end
                ST_SAMPLE: begin
                    r_match <= r_match + {6'd0, FI};
                    r_err   <= r_err + {6'd0, w_mismatch};
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
                    if (w_mismatch && !r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_vec   <= r_vec;
                    end
`endif
                    if (r_vec == 6'd63) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_vec    <= r_vec + 6'd1;
                        r_settle <= LP_SETTLE;
                        r_state  <= ST_DRIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign {A, B, C, D, E, F} = r_vec;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match_count = r_match;
    assign error_count = r_err;
    // A correct comparator asserts FI for exactly 8 of the 64 vectors.
    assign pass        = r_done & (r_err == 7'd0) & (r_match == 7'd8);
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
    assign first_err_valid = r_first_err_valid;
    assign first_err_vec   = r_first_err_vec;
`endif

endmodule

// File: tb/tb_circuito_gerador_vetores_comparador.sv
// Bench for circuito_gerador_vetores_comparador: emulates several comparator
// behaviours on FI and checks results against an arithmetic reference.
module tb_circuito_gerador_vetores_comparador;

    localparam int S       = 1;
    localparam int RUN_LEN = 64 * (S + 1);

    localparam int M_GOOD  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_MISW  = 3;
    localparam int M_RAND  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       fi;
    logic       A, B, C, D, E, F;
    logic       busy, done, pass;
    logic [6:0] match_count, error_count;
    logic [5:0] vec_obs;
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
    logic       first_err_valid;
    logic [5:0] first_err_vec;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          mode  = M_GOOD;
    logic [63:0] rnd_tbl = 64'd0;

    circuito_gerador_vetores_comparador #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .FI          (fi),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .E           (E),
        .F           (F),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .match_count (match_count),
        .error_count (error_count)
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
       ,.first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
`endif
    );

    always #5 clk = ~clk;

    assign vec_obs = {A, B, C, D, E, F};

    // The vector number v is split into triples hi = ABC and lo = DEF.
    // The comparator output is expected high when hi equals DFE.
    function automatic bit gold(input int v);
        int hi;
        int lo;
        hi = v / 8;
        lo = v % 8;
        return hi == ((lo / 4) * 4 + (lo % 2) * 2 + (lo / 2) % 2);
    endfunction

    function automatic bit ref_fi(input int m, input int v, input logic [63:0] tbl);
        case (m)
            M_GOOD:   return gold(v);
            M_STUCK0: return 1'b0;
            M_STUCK1: return 1'b1;
            M_MISW:   return (v / 8) == (v % 8);
            default:  return tbl[v];
        endcase
    endfunction

    always_comb fi = ref_fi(mode, int'(vec_obs), rnd_tbl);

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int m, input bit hold, input bit pulse10, input string tag);
        int lat;
        int em;
        int ee;
        int fe;
        bit f;
        mode  = m;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        lat = 0;
        while (!done && lat < RUN_LEN + 20) begin
            if (pulse10) start = (vec_obs == 6'd10);
            step();
            lat++;
        end
        if (pulse10) start = 1'b0;
        em = 0;
        ee = 0;
        fe = -1;
        for (int v = 0; v < 64; v++) begin
            f = ref_fi(m, v, rnd_tbl);
            em += int'(f);
            if (f != gold(v)) begin
                ee++;
                if (fe < 0) fe = v;
            end
        end
        chk({tag, "_latency"}, lat, RUN_LEN);
        chk({tag, "_match"}, match_count, em);
        chk({tag, "_error"}, error_count, ee);
        chk({tag, "_pass"}, pass, int'(ee == 0 && em == 8));
        chk({tag, "_vec63"}, vec_obs, 63);
        chk({tag, "_busy_end"}, busy, 0);
`ifdef CIRCUITO_GERADOR_CAPTURA_ERRO_EN
        chk({tag, "_fe_valid"}, first_err_valid, int'(fe >= 0));
        chk({tag, "_fe_vec"}, first_err_vec, (fe >= 0) ? fe : 0);
`endif
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec", vec_obs, 0);
        chk("rst_match", match_count, 0);
        chk("rst_error", error_count, 0);
        reset = 1'b0;
        step();

        do_run(M_GOOD, 1'b0, 1'b0, "good");
        // Results hold in DONE while start stays low.
        repeat (3) step();
        chk("hold_done", done, 1);
        chk("hold_match", match_count, 8);
        chk("hold_pass", pass, 1);

        repeat ($urandom_range(0, 5)) step();
        do_run(M_STUCK0, 1'b0, 1'b0, "stuck0");
        repeat ($urandom_range(0, 5)) step();
        do_run(M_STUCK1, 1'b0, 1'b0, "stuck1");
        do_run(M_MISW, 1'b0, 1'b0, "miswired");

        for (int r = 0; r < 4; r++) begin
            rnd_tbl = {$urandom(), $urandom()};
            repeat ($urandom_range(0, 3)) step();
            do_run(M_RAND, 1'b0, 1'b0, "random");
        end

        do_run(M_GOOD, 1'b0, 1'b1, "pulse10");

        // Start held throughout: a single run, then an immediate restart from DONE.
        do_run(M_GOOD, 1'b1, 1'b0, "held");
        step();
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_vec", vec_obs, 0);
        start = 1'b0;

        // A reset in the middle of the run discards partial progress.
        n = 0;
        while (vec_obs != 6'd20 && n < RUN_LEN + 20) begin
            step();
            n++;
        end
        chk("midrst_reach20", vec_obs, 20);
        reset = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_vec", vec_obs, 0);
        chk("midrst_match", match_count, 0);
        chk("midrst_error", error_count, 0);
        // Reset wins over start in the same cycle.
        start = 1'b1;
        step();
        chk("rst_prio_busy", busy, 0);
        start = 1'b0;
        reset = 1'b0;
        step();
        do_run(M_GOOD, 1'b0, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
